// File: rtl/se_pkg.sv
// Shared definitions for the fetch queue.
// NOP constant and the fetch_entry_t storage record.
package se_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Widest program counter an entry can hold.
  // Narrower PC_W values are zero-extended into it.
  localparam int unsigned PC_MAX = 64;

  typedef struct packed {
    logic [31:0]       instr;
    logic [PC_MAX-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/se_fetch_queue.sv
// Fetch-to-decode instruction queue, DEPTH entries, no bypass.
// Ports:
//   clk_i, rst_i (sync, active-high)
//   valid_i/instr_i/pc_i/ready_o : push side (from fetch)
//   valid_o/instr_o/pc_o/ready_i : pop side (to decode)
//   flush_i : drop all entries
//   count_o : occupancy
module se_fetch_queue
  import se_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  input  logic [31:0]              instr_i,
  input  logic [PC_W-1:0]          pc_i,
  output logic                     ready_o,
  input  logic                     flush_i,
  output logic                     valid_o,
  output logic [31:0]              instr_o,
  output logic [PC_W-1:0]          pc_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t mem_q [DEPTH];

  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic         push;
  logic         pop;
  fetch_entry_t head;
  fetch_entry_t wentry;

  // Full blocks pushes even when a pop happens this cycle.
  assign ready_o = (cnt_q < CW'(DEPTH));
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;

  assign push = valid_i && ready_o;
  assign pop  = valid_o && ready_i;

  assign head    = mem_q[rd_q];
  assign instr_o = valid_o ? head.instr : NOP;
  assign pc_o    = valid_o ? PC_W'(head.pc) : '0;

  always_comb begin
    wentry       = '0;
    wentry.instr = instr_i;
    wentry.pc    = PC_MAX'(pc_i);
  end

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is not reset; the count alone marks what is live.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i && !rst_i) begin
      mem_q[wr_q] <= wentry;
    end
  end

endmodule

// File: tb/tb_se_fetch_queue.sv
// Directed self-checking bench for se_fetch_queue.
// Drives 1ns after each rising edge, checks before the next.
module tb_se_fetch_queue;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [31:0] instr_i;
  logic [63:0] pc_i;
  logic        ready_o;
  logic        flush_i;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [63:0] pc_o;
  logic        ready_i;
  logic [2:0]  count_o;

  int n_cmp = 0;
  int n_bad = 0;

  se_fetch_queue #(.DEPTH(4), .PC_W(64)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .instr_i (instr_i),
    .pc_i    (pc_i),
    .ready_o (ready_o),
    .flush_i (flush_i),
    .valid_o (valid_o),
    .instr_o (instr_o),
    .pc_o    (pc_o),
    .ready_i (ready_i),
    .count_o (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i   = 1'b1;
    valid_i = 1'b0;
    instr_i = '0;
    pc_i    = '0;
    flush_i = 1'b0;
    ready_i = 1'b0;

    // Reset then idle
    tick();
    tick();
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_instr", 64'(instr_o), 64'h13);
    chk("rst_pc", pc_o, 64'd0);
    rst_i = 1'b0;
    tick();
    chk("idle_valid", 64'(valid_o), 64'd0);

    // Single push then pop
    valid_i = 1'b1;
    instr_i = 32'h0050_0093;
    pc_i    = 64'h1000;
    chk("p1_nobypass", 64'(valid_o), 64'd0);
    tick();
    valid_i = 1'b0;
    chk("p1_valid", 64'(valid_o), 64'd1);
    chk("p1_instr", 64'(instr_o), 64'h0050_0093);
    chk("p1_pc", pc_o, 64'h1000);
    chk("p1_count", 64'(count_o), 64'd1);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk("pop1_valid", 64'(valid_o), 64'd0);
    chk("pop1_count", 64'(count_o), 64'd0);
    chk("pop1_instr", 64'(instr_o), 64'h13);
    chk("pop1_pc", pc_o, 64'd0);

    // Fill to full, fifth push refused
    for (int i = 0; i < 5; i++) begin
      valid_i = 1'b1;
      instr_i = 32'h100 + 32'(i);
      pc_i    = 64'(i * 4);
      chk($sformatf("fill_ready%0d", i), 64'(ready_o),
          (i < 4) ? 64'd1 : 64'd0);
      tick();
    end
    valid_i = 1'b0;
    chk("full_count", 64'(count_o), 64'd4);
    chk("full_ready", 64'(ready_o), 64'd0);
    chk("full_head", pc_o, 64'h0);
    chk("full_hinstr", 64'(instr_o), 64'h100);

    // Full plus pop: only the pop happens
    valid_i = 1'b1;
    pc_i    = 64'h10;
    ready_i = 1'b1;
    chk("fp_ready", 64'(ready_o), 64'd0);
    tick();
    valid_i = 1'b0;
    chk("fp_count", 64'(count_o), 64'd3);
    chk("drain_pc4", pc_o, 64'h4);
    tick();
    chk("drain_pc8", pc_o, 64'h8);
    tick();
    chk("drain_pcC", pc_o, 64'hC);
    tick();
    chk("drain_valid", 64'(valid_o), 64'd0);
    chk("drain_count", 64'(count_o), 64'd0);

    // Streaming across three pointer wraps
    ready_i = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      valid_i = (k < 12);
      pc_i    = 64'(k * 4);
      instr_i = 32'h200 + 32'(k);
      chk($sformatf("st_cnt%0d", k), 64'(count_o <= 3'd1), 64'd1);
      if (k > 0) begin
        chk($sformatf("st_v%0d", k), 64'(valid_o), 64'd1);
        chk($sformatf("st_pc%0d", k), pc_o, 64'((k - 1) * 4));
      end
      tick();
    end
    valid_i = 1'b0;
    ready_i = 1'b0;
    chk("st_end", 64'(count_o), 64'd0);

    // Flush with same-cycle push
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1;
      pc_i    = 64'h100 + 64'(i * 4);
      tick();
    end
    chk("fl_pre", 64'(count_o), 64'd3);
    flush_i = 1'b1;
    pc_i    = 64'h2000;
    tick();
    flush_i = 1'b0;
    valid_i = 1'b0;
    chk("fl_count", 64'(count_o), 64'd0);
    chk("fl_valid", 64'(valid_o), 64'd0);
    chk("fl_pc", pc_o, 64'd0);
    chk("fl_ready", 64'(ready_o), 64'd1);
    valid_i = 1'b1;
    pc_i    = 64'h3000;
    tick();
    valid_i = 1'b0;
    chk("post_fl_pc", pc_o, 64'h3000);
    chk("post_fl_cnt", 64'(count_o), 64'd1);

    // Reset mid-operation beats every other input
    valid_i = 1'b1;
    pc_i    = 64'h4000;
    tick();
    chk("mr_pre", 64'(count_o), 64'd2);
    rst_i   = 1'b1;
    ready_i = 1'b1;
    pc_i    = 64'h5000;
    tick();
    rst_i   = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    chk("mr_count", 64'(count_o), 64'd0);
    chk("mr_valid", 64'(valid_o), 64'd0);
    chk("mr_instr", 64'(instr_o), 64'h13);
    valid_i = 1'b1;
    pc_i    = 64'h6000;
    tick();
    valid_i = 1'b0;
    chk("mr_ptr_pc", pc_o, 64'h6000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
